// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider, 32-bit, {quotient, remainder} result after 32 iterations.
// Optional DIV_ZERO_FAST_EN: a zero divisor bypasses the iterations and reports in the next cycle.
module iter_divider #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic        cancel,
  output logic [63:0] m_axis_dout_tdata,
  output logic        m_axis_dout_tvalid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] dout_q, dout_d;
  logic        dout_vld_q, dout_vld_d;
  logic        rdy_q, rdy_d;

  logic        accept_s;
  logic        sa_s, sb_s;
  logic [33:0] rem_shift_s;
  logic [33:0] trial_s;
  logic        ge_s;
  logic [32:0] rem_nx_s;
  logic [31:0] quo_nx_s;
  logic [31:0] q_res_s;
  logic [31:0] r_res_s;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    mag32 = (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Next-state, datapath iteration and result formation
  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;

    accept_s = (state_q == S_IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid && !cancel;
    sa_s     = SIGNED && s_axis_dividend_tdata[31];
    sb_s     = SIGNED && s_axis_divisor_tdata[31];

    // rem_q[32] is always 0 here; the 34-bit trial's sign bit gives rem >= divisor
    rem_shift_s = {rem_q, dvd_q[31]};
    trial_s     = rem_shift_s - {2'b00, dvs_q};
    ge_s        = ~trial_s[33];
    rem_nx_s    = ge_s ? trial_s[32:0] : rem_shift_s[32:0];
    quo_nx_s    = {dvd_q[30:0], ge_s};
    q_res_s     = neg_quo_q ? (32'd0 - quo_nx_s) : quo_nx_s;
    r_res_s     = neg_rem_q ? (32'd0 - rem_nx_s[31:0]) : rem_nx_s[31:0];

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          dvd_d     = mag32(s_axis_dividend_tdata, SIGNED);
          dvs_d     = mag32(s_axis_divisor_tdata, SIGNED);
          neg_quo_d = sa_s ^ sb_s;
          neg_rem_d = sa_s;
          rem_d     = 33'd0;
          cnt_d     = 6'd0;
`ifdef DIV_ZERO_FAST_EN
          if (s_axis_divisor_tdata == 32'd0) begin
            dout_d     = {(sa_s ? 32'h0000_0001 : 32'hFFFF_FFFF), s_axis_dividend_tdata};
            dout_vld_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
`else
          state_d = S_BUSY;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx_s;
          dvd_d = quo_nx_s;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            dout_d     = {q_res_s, r_res_s};
            dout_vld_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rdy_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dvd_q      <= 32'd0;
      dvs_q      <= 32'd0;
      rem_q      <= 33'd0;
      cnt_q      <= 6'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dout_q     <= 64'd0;
      dout_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign s_axis_divisor_tready  = rdy_q;
  assign s_axis_dividend_tready = rdy_q;
  assign m_axis_dout_tdata      = dout_q;
  assign m_axis_dout_tvalid     = dout_vld_q;

endmodule
